beat_scheduler: RTL and testbench
=================================

BEAT_SCHEDULER -- requirements
Module: beat_scheduler

Interface
REQ-001 The block SHALL have parameter REFRACT_TICKS, default 200: sample ticks after an accepted beat during which crossings are ignored.
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 3000: sample ticks without an accepted beat before signal-lost is declared.
REQ-003 The block SHALL have parameter CNT_W, default 12: interval counter width, with 2^CNT_W-1 >= TIMEOUT_TICKS and REFRACT_TICKS < TIMEOUT_TICKS.
REQ-004 The block SHALL have port clk, input, 1: system clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable, input, 1: run request; low forces IDLE.
REQ-007 The block SHALL have port sample_tick, input, 1: one-cycle strobe marking a new comparator result.
REQ-008 The block SHALL have port over, input, 1: comparator output, 1 when the sample exceeds the threshold.
REQ-009 The block SHALL have port beat, output, 1: one-cycle pulse per accepted beat.
REQ-010 The block SHALL have port interval, output, CNT_W: ticks between the last two accepted beats.
REQ-011 The block SHALL have port interval_valid, output, 1: one-cycle pulse when interval is updated.
REQ-012 The block SHALL have port timeout, output, 1: one-cycle pulse when signal-lost is declared.
REQ-013 The block SHALL have port lost, output, 1: level, set by timeout and cleared by the next accepted beat.
REQ-014 The block SHALL have port beat_count, output, 16: accepted-beat counter, wrapping 0xFFFF to 0x0000.
REQ-015 The block SHALL have port state, output, 2: FSM state, IDLE=0, WAIT_FIRST=1, REFRACT=2, ARMED=3.

Function
REQ-016 All outputs SHALL be registered, and all decisions SHALL be taken only in cycles where sample_tick=1, except the enable-low forcing to IDLE.
REQ-017 Register over_q SHALL load over on each sample_tick; a rising edge SHALL be sample_tick & over & ~over_q.
REQ-018 In IDLE, over_q SHALL be held at 1, so a level already high at enable produces no edge.
REQ-019 Counter d SHALL clear to 0 on the tick of an accepted beat and SHALL increment by 1 on each later tick, saturating at TIMEOUT_TICKS.
REQ-020 IDLE SHALL go to WAIT_FIRST on the first clock with enable=1.
REQ-021 In WAIT_FIRST, an edge SHALL produce: beat=1, beat_count+1, lost=0, d cleared, transition to REFRACT, and no interval_valid.
REQ-022 In REFRACT, edges SHALL be ignored (over_q still updates), and the FSM SHALL go to ARMED on the tick where d becomes REFRACT_TICKS.
REQ-023 In ARMED, an edge on the tick making d equal to k SHALL produce: beat=1, interval=k, interval_valid=1, beat_count+1, lost=0, d cleared, transition to REFRACT.
REQ-024 The minimum accepted interval SHALL therefore be REFRACT_TICKS+1.
REQ-025 In REFRACT or ARMED, the tick where d reaches TIMEOUT_TICKS without an accepted edge SHALL produce: timeout=1, lost=1, transition to WAIT_FIRST.
REQ-026 An edge on that same tick SHALL win: the beat is accepted with interval=TIMEOUT_TICKS, and no timeout is raised.
REQ-027 When enable=0, the next clock SHALL force IDLE and clear d, beat, interval_valid and timeout, overriding any simultaneous tick or edge.
REQ-028 When enable=0, interval, lost and beat_count SHALL hold their values.
REQ-029 beat, interval_valid and timeout SHALL never exceed one cycle, and SHALL each be raised at most once per sample_tick.

Reset
REQ-030 While rst_n=0, regardless of clk, the block SHALL set state=IDLE, d=0, over_q=1, and all outputs to 0.
REQ-031 A reset asserted mid-operation SHALL discard any partial interval, and the first beat after release SHALL be treated as a first beat.

Verification
REQ-032 Assert rst_n=0 while in ARMED with d=500 -> immediately state=0 and all outputs 0; after release with enable=1, the first edge gives beat but no interval_valid.
REQ-033 Edges at ticks 10 and 810 -> beat on both; interval=800 with interval_valid on the second only; beat_count=2.
REQ-034 Edge at tick 10, then edges at d=150 and d=200 -> both ignored; edge at d=201 -> accepted with interval=201.
REQ-035 Edge then no edge for 3000 ticks -> timeout pulse and lost=1 at d=3000, state=WAIT_FIRST; next edge gives beat, lost=0, no interval_valid.
REQ-036 Edge exactly at d=3000 -> beat with interval=3000 and no timeout.
REQ-037 over=1 when enable rises -> no beat; over falls, then rises -> one beat.

Source files
------------

// File: rtl/beat_scheduler.sv
// Heartbeat-style beat scheduler: accepts comparator rising edges outside a refractory
// window, measures beat-to-beat intervals and flags loss of signal after a timeout.
module beat_scheduler #(
    parameter int unsigned REFRACT_TICKS = 200,
    parameter int unsigned TIMEOUT_TICKS = 3000,
    parameter int unsigned CNT_W         = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_tick,
    input  logic             over,
    output logic             beat,
    output logic [CNT_W-1:0] interval,
    output logic             interval_valid,
    output logic             timeout,
    output logic             lost,
    output logic [15:0]      beat_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitFirst = 2'd1,
        StRefract   = 2'd2,
        StArmed     = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] RefractVal = CNT_W'(REFRACT_TICKS);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_TICKS);

    state_e           st_q;
    logic             over_q;
    logic [CNT_W-1:0] d_q;
    logic [CNT_W-1:0] d_inc;
    logic             rise;

    assign rise  = sample_tick & over & ~over_q;
    assign d_inc = (d_q >= TimeoutVal) ? TimeoutVal : d_q + 1'b1;
    assign state = st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q           <= StIdle;
            over_q         <= 1'b1;
            d_q            <= '0;
            beat           <= 1'b0;
            interval       <= '0;
            interval_valid <= 1'b0;
            timeout        <= 1'b0;
            lost           <= 1'b0;
            beat_count     <= '0;
        end else begin
            beat           <= 1'b0;
            interval_valid <= 1'b0;
            timeout        <= 1'b0;
            if (!enable) begin
                st_q   <= StIdle;
                d_q    <= '0;
                over_q <= 1'b1;
            end else begin
                case (st_q)
                    StIdle: begin
                        // Holding over_q high means a level already high at enable is no edge.
                        over_q <= 1'b1;
                        d_q    <= '0;
                        st_q   <= StWaitFirst;
                    end
                    StWaitFirst: begin
                        if (sample_tick) begin
                            over_q <= over;
                            if (rise) begin
                                beat       <= 1'b1;
                                beat_count <= beat_count + 16'd1;
                                lost       <= 1'b0;
                                d_q        <= '0;
                                st_q       <= StRefract;
                            end else begin
                                d_q <= d_inc;
                            end
                        end
                    end
                    StRefract: begin
                        if (sample_tick) begin
                            over_q <= over;
                            d_q    <= d_inc;
                            if (d_inc == TimeoutVal) begin
                                timeout <= 1'b1;
                                lost    <= 1'b1;
                                st_q    <= StWaitFirst;
                            end else if (d_inc >= RefractVal) begin
                                st_q <= StArmed;
                            end
                        end
                    end
                    StArmed: begin
                        if (sample_tick) begin
                            over_q <= over;
                            // An edge on the timeout tick wins over the timeout.
                            if (rise) begin
                                beat           <= 1'b1;
                                interval       <= d_inc;
                                interval_valid <= 1'b1;
                                beat_count     <= beat_count + 16'd1;
                                lost           <= 1'b0;
                                d_q            <= '0;
                                st_q           <= StRefract;
                            end else begin
                                d_q <= d_inc;
                                if (d_inc == TimeoutVal) begin
                                    timeout <= 1'b1;
                                    lost    <= 1'b1;
                                    st_q    <= StWaitFirst;
                                end
                            end
                        end
                    end
                    default: st_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beat_scheduler.sv
// Scoreboard bench for beat_scheduler: stimulus queues expected output events, a monitor
// pops and compares them whenever the DUT pulses beat, interval_valid or timeout.
module tb_beat_scheduler;

    localparam int CNT_W = 12;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             sample_tick;
    logic             over;
    logic             beat;
    logic [CNT_W-1:0] interval;
    logic             interval_valid;
    logic             timeout;
    logic             lost;
    logic [15:0]      beat_count;
    logic [1:0]       state;

    beat_scheduler #(
        .REFRACT_TICKS(200),
        .TIMEOUT_TICKS(3000),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_tick   (sample_tick),
        .over          (over),
        .beat          (beat),
        .interval      (interval),
        .interval_valid(interval_valid),
        .timeout       (timeout),
        .lost          (lost),
        .beat_count    (beat_count),
        .state         (state)
    );

    typedef struct packed {
        logic        beat;
        logic        iv;
        logic [11:0] interval;
        logic        timeout;
        logic        lost;
        logic [15:0] count;
        logic [1:0]  state;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_count = 0;
    int  exp_interval = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (beat || interval_valid || timeout)) begin
            ev_t a;
            ev_t e;
            a = '{beat, interval_valid, interval, timeout, lost, beat_count, state};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual=%h required=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a != e) begin
                    errors++;
                    $display("FAIL event actual=%h required=%h", a, e);
                end
            end
        end
    end

    task automatic tick(input logic ov);
        sample_tick = 1'b1;
        over        = ov;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Edge that must be accepted; first=1 means no interval is reported.
    task automatic good_edge(input bit first, input int k);
        exp_count++;
        if (!first) exp_interval = k;
        exp_q.push_back('{1'b1, !first, 12'(exp_interval), 1'b0, 1'b0, 16'(exp_count), 2'd2});
        tick(1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_count    = 0;
        exp_interval = 0;
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; sample_tick = 1'b0; over = 1'b0;
        do_reset();
        check("rst_state", state, 0);
        check("rst_outputs", {beat, interval_valid, timeout, lost}, 0);
        check("rst_count", beat_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("wait_first", state, 1);

        // Edges at ticks 10 and 810 -> interval 800.
        idle(9);
        good_edge(1, 0);
        idle(799);
        good_edge(0, 800);
        check("count_two", beat_count, 2);

        // Refractory: edges at d=150 and d=200 ignored, then one at d=250 accepted.
        idle(149);
        tick(1'b1);
        idle(49);
        tick(1'b1);
        check("armed_at_200", state, 3);
        idle(49);
        good_edge(0, 250);
        // Minimum accepted interval 201.
        idle(200);
        good_edge(0, 201);

        // Edge exactly at d=3000 wins over timeout.
        idle(2999);
        good_edge(0, 3000);
        check("lost_after_3000_beat", lost, 0);

        // No edge for 3000 ticks -> timeout.
        idle(2999);
        exp_q.push_back('{1'b0, 1'b0, 12'(exp_interval), 1'b1, 1'b1, 16'(exp_count), 2'd1});
        tick(1'b0);
        check("lost_set", lost, 1);
        check("state_wait_first", state, 1);
        idle(5);
        good_edge(1, 0);
        check("lost_cleared", lost, 0);

        // Reset in ARMED with d=500.
        idle(500);
        check("armed_500", state, 3);
        do_reset();
        check("midrst_state", state, 0);
        check("midrst_outputs", {beat, interval_valid, timeout, lost}, 0);
        check("midrst_count", beat_count, 0);
        check("midrst_interval", interval, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        idle(3);
        good_edge(1, 0);

        // Enable low overrides a simultaneous edge in ARMED; outputs hold.
        idle(250);
        enable      = 1'b0;
        sample_tick = 1'b1;
        over        = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        check("disable_idle", state, 0);
        check("disable_count_hold", beat_count, exp_count);
        check("disable_interval_hold", interval, exp_interval);

        // over already high at enable -> no beat until it falls and rises again.
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) tick(1'b1);
        check("no_beat_high_level", beat_count, exp_count);
        tick(1'b0);
        good_edge(1, 0);
        idle(3);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
